// File: rtl/wb_stage_exc_pkg.sv
// Shared definitions for the writeback stage: exception codes, vector bit
// positions and the stage state encoding.
package wb_stage_exc_pkg;

    localparam int unsigned EXC_W    = 6;
    localparam int unsigned ECODE_W  = 6;
    localparam int unsigned ESUB_W   = 9;

    // Bit positions inside the {ale, brk, sys, ine, adef, int} vector
    localparam int unsigned EXC_INT  = 0;
    localparam int unsigned EXC_ADEF = 1;
    localparam int unsigned EXC_INE  = 2;
    localparam int unsigned EXC_SYS  = 3;
    localparam int unsigned EXC_BRK  = 4;
    localparam int unsigned EXC_ALE  = 5;

    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
    localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;
    localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
    localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
    localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_exc_if.sv
// MEM -> WB handshake and payload bundle.
interface wb_stage_exc_if
    import wb_stage_exc_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
);
    logic                ms_to_ws_valid;
    logic                ws_allowin;
    logic [DW-1:0]       ms_pc;
    logic [RW+DW:0]      ms_rf_collect;
    logic [EXC_W-1:0]    ms_exc_vec;
    logic                ms_ertn;
    logic [DW-1:0]       ms_badv;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_rf_collect, ms_exc_vec, ms_ertn, ms_badv,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_rf_collect, ms_exc_vec, ms_ertn, ms_badv,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage_exc_prio_enc.sv
// Fixed-priority exception encoder: INT > ADEF > INE > SYS > BRK > ALE.
module wb_stage_exc_prio_enc
    import wb_stage_exc_pkg::*;
(
    input  logic [EXC_W-1:0]   i_exc_vec,
    output logic               o_any,
    output logic [ECODE_W-1:0] o_ecode,
    output logic               o_is_adef,
    output logic               o_is_ale
);
    always_comb begin
        o_any     = |i_exc_vec;
        o_ecode   = ECODE_INT;
        o_is_adef = 1'b0;
        o_is_ale  = 1'b0;
        if (i_exc_vec[EXC_INT]) begin
            o_ecode = ECODE_INT;
        end else if (i_exc_vec[EXC_ADEF]) begin
            o_ecode   = ECODE_ADEF;
            o_is_adef = 1'b1;
        end else if (i_exc_vec[EXC_INE]) begin
            o_ecode = ECODE_INE;
        end else if (i_exc_vec[EXC_SYS]) begin
            o_ecode = ECODE_SYS;
        end else if (i_exc_vec[EXC_BRK]) begin
            o_ecode = ECODE_BRK;
        end else if (i_exc_vec[EXC_ALE]) begin
            o_ecode  = ECODE_ALE;
            o_is_ale = 1'b1;
        end
    end
endmodule

// File: rtl/wb_stage_exc.sv
// Writeback stage: latches the MEM payload, commits the RF write, resolves
// exceptions/ertn against the CSR handshake and enforces a post-flush hold.
module wb_stage_exc
    import wb_stage_exc_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned RW         = 5,
    parameter int unsigned FLUSH_HOLD = 2
)(
    input  logic                clk,
    input  logic                reset,
    wb_stage_exc_if.slave       ms,
    input  logic                csr_ready,
    output logic [RW+DW:0]      ws_rf_collect,
    output logic                wb_ex,
    output logic                ertn_flush,
    output logic [ECODE_W-1:0]  wb_ecode,
    output logic [ESUB_W-1:0]   wb_esubcode,
    output logic [DW-1:0]       wb_pc,
    output logic [DW-1:0]       wb_vaddr,
    output logic                flush_busy,
    output logic [DW-1:0]       debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [RW-1:0]       debug_wb_rf_wnum,
    output logic [DW-1:0]       debug_wb_rf_wdata
);
    localparam int unsigned CNT_W     = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam int unsigned HOLD_LOAD = (FLUSH_HOLD > 0) ? FLUSH_HOLD - 1 : 0;

    logic               r_ws_valid;
    logic [DW-1:0]      r_pc;
    logic [DW-1:0]      r_badv;
    logic [RW+DW:0]     r_rf;
    logic [EXC_W-1:0]   r_exc;
    logic               r_ertn;
    wb_state_e          r_state;
    logic [CNT_W-1:0]   r_hold_cnt;

    logic               w_any;
    logic [ECODE_W-1:0] w_ecode;
    logic               w_is_adef;
    logic               w_is_ale;
    logic               w_has_evt;
    logic               w_ready_go;
    logic               w_allowin;
    logic               w_ex;
    logic               w_ertn;
    logic               w_flush;
    logic               w_rf_wen;
    logic               w_latch;

    wb_stage_exc_prio_enc u_prio (
        .i_exc_vec (r_exc),
        .o_any     (w_any),
        .o_ecode   (w_ecode),
        .o_is_adef (w_is_adef),
        .o_is_ale  (w_is_ale)
    );

    // Commit pulses are suppressed in a reset cycle so a pending WAIT never fires
    assign w_has_evt  = w_any | r_ertn;
    assign w_ready_go = ~w_has_evt | csr_ready;
    assign w_allowin  = (r_state != ST_HOLD) & (~r_ws_valid | w_ready_go);
    assign w_ex       = ~reset & r_ws_valid & w_any & csr_ready;
    assign w_ertn     = ~reset & r_ws_valid & r_ertn & ~w_any & csr_ready;
    assign w_flush    = w_ex | w_ertn;
    assign w_rf_wen   = r_ws_valid & ~w_any & ~r_ertn & r_rf[RW+DW];
    assign w_latch    = ms.ms_to_ws_valid & w_allowin & ~w_flush;

    // Payload registers; an incoming instruction is dropped in a flush cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
            r_pc       <= '0;
            r_badv     <= '0;
            r_rf       <= '0;
            r_exc      <= '0;
            r_ertn     <= 1'b0;
        end else begin
            if (w_flush) begin
                r_ws_valid <= 1'b0;
            end else if (w_allowin) begin
                r_ws_valid <= ms.ms_to_ws_valid;
            end
            if (w_latch) begin
                r_pc   <= ms.ms_pc;
                r_badv <= ms.ms_badv;
                r_rf   <= ms.ms_rf_collect;
                r_exc  <= ms.ms_exc_vec;
                r_ertn <= ms.ms_ertn;
            end
        end
    end

    // Flush FSM with post-flush hold counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_WAIT: begin
                    if (r_ws_valid & w_has_evt) begin
                        if (csr_ready) begin
                            if (FLUSH_HOLD == 0) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_state    <= ST_HOLD;
                                r_hold_cnt <= CNT_W'(HOLD_LOAD);
                            end
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    assign ms.ws_allowin     = w_allowin;
    assign wb_ex             = w_ex;
    assign ertn_flush        = w_ertn;
    assign wb_ecode          = r_ws_valid ? w_ecode : '0;
    assign wb_esubcode       = '0;
    assign wb_pc             = r_ws_valid ? r_pc : '0;
    assign wb_vaddr          = ~r_ws_valid ? '0 :
                               w_is_adef   ? r_pc :
                               w_is_ale    ? r_badv : '0;
    assign flush_busy        = (r_state == ST_HOLD);
    assign ws_rf_collect     = {w_rf_wen, r_rf[RW+DW-1:0]};
    assign debug_wb_pc       = r_ws_valid ? r_pc : '0;
    assign debug_wb_rf_we    = {4{w_rf_wen}};
    assign debug_wb_rf_wnum  = r_rf[RW+DW-1:DW];
    assign debug_wb_rf_wdata = r_rf[DW-1:0];

endmodule

// File: tb/tb_wb_stage_exc.sv
// Directed bench for wb_stage_exc: plain commit, exceptions, ertn, WAIT, HOLD and reset recovery.
module tb_wb_stage_exc;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic reset;
    logic csr_ready;

    logic [RW+DW:0] ws_rf_collect;
    logic           wb_ex, ertn_flush, flush_busy;
    logic [5:0]     wb_ecode;
    logic [8:0]     wb_esubcode;
    logic [DW-1:0]  wb_pc, wb_vaddr, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]     debug_wb_rf_we;
    logic [RW-1:0]  debug_wb_rf_wnum;

    int n_vec = 0;
    int n_err = 0;

    wb_stage_exc_if #(.DW(DW), .RW(RW)) ms_if ();

    wb_stage_exc #(.DW(DW), .RW(RW), .FLUSH_HOLD(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms                (ms_if.slave),
        .csr_ready         (csr_ready),
        .ws_rf_collect     (ws_rf_collect),
        .wb_ex             (wb_ex),
        .ertn_flush        (ertn_flush),
        .wb_ecode          (wb_ecode),
        .wb_esubcode       (wb_esubcode),
        .wb_pc             (wb_pc),
        .wb_vaddr          (wb_vaddr),
        .flush_busy        (flush_busy),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [37:0] rf,
                         input logic [5:0] exc, input logic ertn, input logic [31:0] badv);
        ms_if.ms_to_ws_valid = v;
        ms_if.ms_pc          = pc;
        ms_if.ms_rf_collect  = rf;
        ms_if.ms_exc_vec     = exc;
        ms_if.ms_ertn        = ertn;
        ms_if.ms_badv        = badv;
    endtask

    initial begin
        reset     = 1'b1;
        csr_ready = 1'b0;
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);

        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_allowin", 64'(ms_if.ws_allowin), 64'h1);
        check("rst_flush_busy", 64'(flush_busy), 64'h0);
        check("rst_wb_ex", 64'(wb_ex), 64'h0);
        check("rst_ertn", 64'(ertn_flush), 64'h0);
        check("rst_rf_collect", 64'(ws_rf_collect), 64'h0);
        check("rst_dbg_pc", 64'(debug_wb_pc), 64'h0);
        check("rst_dbg_we", 64'(debug_wb_rf_we), 64'h0);
        reset = 1'b0;

        // 2: plain write
        drive(1'b1, 32'h1C00_0000, {1'b1, 5'd3, 32'hDEAD_BEEF}, 6'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("w_dbg_we", 64'(debug_wb_rf_we), 64'hF);
        check("w_dbg_wnum", 64'(debug_wb_rf_wnum), 64'h3);
        check("w_dbg_wdata", 64'(debug_wb_rf_wdata), 64'hDEAD_BEEF);
        check("w_dbg_pc", 64'(debug_wb_pc), 64'h1C00_0000);
        check("w_rf_collect", 64'(ws_rf_collect), 64'h23_DEAD_BEEF);
        check("w_esub", 64'(wb_esubcode), 64'h0);
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);
        @(negedge clk);
        check("w_we_off", 64'(debug_wb_rf_we), 64'h0);
        check("w_pc_off", 64'(debug_wb_pc), 64'h0);

        // 3: SYS|ALE with csr_ready: SYS wins, hold window of 2 cycles
        csr_ready = 1'b1;
        drive(1'b1, 32'h1C00_0004, {1'b1, 5'd7, 32'h0000_1234}, 6'h28, 1'b0, 32'h1000_0003);
        @(negedge clk);
        check("sys_wb_ex", 64'(wb_ex), 64'h1);
        check("sys_ecode", 64'(wb_ecode), 64'h0B);
        check("sys_vaddr", 64'(wb_vaddr), 64'h0);
        check("sys_no_we", 64'(debug_wb_rf_we), 64'h0);
        check("sys_rfc_we", 64'(ws_rf_collect[37]), 64'h0);
        check("sys_ertn", 64'(ertn_flush), 64'h0);
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("sys_hold_busy", 64'(flush_busy), 64'h1);
            check("sys_hold_allowin", 64'(ms_if.ws_allowin), 64'h0);
            check("sys_hold_ex", 64'(wb_ex), 64'h0);
        end
        @(negedge clk);
        check("sys_end_busy", 64'(flush_busy), 64'h0);
        check("sys_end_allowin", 64'(ms_if.ws_allowin), 64'h1);

        // 4: ALE waiting on the CSR unit; a newer payload must not overwrite
        csr_ready = 1'b0;
        drive(1'b1, 32'h1C00_0008, {1'b1, 5'd9, 32'h0000_0055}, 6'h20, 1'b0, 32'h1000_0003);
        @(negedge clk);
        drive(1'b1, 32'h1C00_0100, {1'b1, 5'd2, 32'h0000_0066}, 6'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ale_wait_allowin", 64'(ms_if.ws_allowin), 64'h0);
            check("ale_wait_ex", 64'(wb_ex), 64'h0);
            check("ale_wait_pc", 64'(wb_pc), 64'h1C00_0008);
            check("ale_wait_ecode", 64'(wb_ecode), 64'h09);
        end
        csr_ready = 1'b1;
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);
        #1;
        check("ale_wb_ex", 64'(wb_ex), 64'h1);
        check("ale_vaddr", 64'(wb_vaddr), 64'h1000_0003);
        @(negedge clk);
        check("ale_after_ex", 64'(wb_ex), 64'h0);
        check("ale_after_pc", 64'(wb_pc), 64'h0);
        check("ale_hold_busy", 64'(flush_busy), 64'h1);
        repeat (2) @(negedge clk);
        check("ale_end_busy", 64'(flush_busy), 64'h0);

        // 5: ertn commit drops the same-cycle incoming payload
        drive(1'b1, 32'h1C00_000C, {1'b1, 5'd4, 32'h0000_0077}, 6'h0, 1'b1, 32'h0);
        @(negedge clk);
        check("ertn_flush", 64'(ertn_flush), 64'h1);
        check("ertn_wb_ex", 64'(wb_ex), 64'h0);
        check("ertn_no_we", 64'(debug_wb_rf_we), 64'h0);
        check("ertn_allowin", 64'(ms_if.ws_allowin), 64'h1);
        drive(1'b1, 32'h1C00_0010, {1'b1, 5'd5, 32'h0000_0099}, 6'h0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);
        check("ertn_pulse_end", 64'(ertn_flush), 64'h0);
        check("ertn_dropped_pc", 64'(debug_wb_pc), 64'h0);
        check("ertn_dropped_we", 64'(debug_wb_rf_we), 64'h0);
        check("ertn_busy", 64'(flush_busy), 64'h1);
        repeat (2) @(negedge clk);
        check("ertn_end_busy", 64'(flush_busy), 64'h0);
        check("ertn_end_we", 64'(debug_wb_rf_we), 64'h0);

        // ADEF outranks INE; BADV is the pc
        drive(1'b1, 32'h1C00_0020, {1'b1, 5'd6, 32'h0}, 6'h06, 1'b0, 32'h2222_2222);
        @(negedge clk);
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);
        check("adef_ex", 64'(wb_ex), 64'h1);
        check("adef_ecode", 64'(wb_ecode), 64'h08);
        check("adef_vaddr", 64'(wb_vaddr), 64'h1C00_0020);
        repeat (3) @(negedge clk);

        // 6: all exceptions -> INT, then reset during HOLD
        drive(1'b1, 32'h1C00_0030, {1'b1, 5'd8, 32'h0}, 6'h3F, 1'b1, 32'h3333_3333);
        @(negedge clk);
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);
        check("int_ex", 64'(wb_ex), 64'h1);
        check("int_ecode", 64'(wb_ecode), 64'h00);
        check("int_no_ertn", 64'(ertn_flush), 64'h0);
        @(negedge clk);
        check("int_hold_busy", 64'(flush_busy), 64'h1);
        reset = 1'b1;
        #1;
        check("rh_no_ex", 64'(wb_ex), 64'h0);
        @(negedge clk);
        check("rh_busy", 64'(flush_busy), 64'h0);
        check("rh_allowin", 64'(ms_if.ws_allowin), 64'h1);
        check("rh_no_pulse", 64'({wb_ex, ertn_flush}), 64'h0);
        reset = 1'b0;

        // Reset during WAIT must not release the pending ertn
        csr_ready = 1'b0;
        drive(1'b1, 32'h1C00_0040, {1'b1, 5'd1, 32'h0}, 6'h0, 1'b1, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 38'h0, 6'h0, 1'b0, 32'h0);
        check("rw_valid_pc", 64'(debug_wb_pc), 64'h1C00_0040);
        @(negedge clk);
        check("rw_wait_allowin", 64'(ms_if.ws_allowin), 64'h0);
        reset     = 1'b1;
        csr_ready = 1'b1;
        #1;
        check("rw_no_ertn", 64'(ertn_flush), 64'h0);
        @(negedge clk);
        check("rw_pc_clr", 64'(debug_wb_pc), 64'h0);
        check("rw_allowin", 64'(ms_if.ws_allowin), 64'h1);
        check("rw_busy", 64'(flush_busy), 64'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rw_quiet", 64'({wb_ex, ertn_flush}), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
